// File: rtl/segre_pkg.sv
// Shared Segre core constants and types.
package segre_pkg;

  localparam int unsigned ADDR_SIZE             = 32;
  localparam int unsigned WORD_SIZE             = 32;
  localparam int unsigned CACHE_LINE_SIZE_BYTES = 16;

  // Shared memory-port arbiter states
  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_IF_RD,
    ARB_DC_WB,
    ARB_DC_RD,
    ARB_RESP
  } arb_state_e;

endpackage

// File: rtl/segre_mem_arbiter.sv
// Round-robin arbiter serialising icache refills and dcache refills/writebacks
// onto a single line-wide memory handshake.
module segre_mem_arbiter
  import segre_pkg::*;
#(
  parameter int unsigned LINE_BYTES  = CACHE_LINE_SIZE_BYTES,
  parameter int unsigned OFFSET_BITS = $clog2(LINE_BYTES)
) (
  input  logic                        clk_i,
  input  logic                        rsn_i,
  // icache
  input  logic                        if_rd_i,
  input  logic [ADDR_SIZE-1:0]        if_addr_i,
  output logic [LINE_BYTES-1:0][7:0]  if_line_o,
  output logic                        if_ready_o,
  // dcache
  input  logic                        dc_rd_i,
  input  logic                        dc_wr_i,
  input  logic [ADDR_SIZE-1:0]        dc_rd_addr_i,
  input  logic [ADDR_SIZE-1:0]        dc_wr_addr_i,
  input  logic [LINE_BYTES-1:0][7:0]  dc_wr_line_i,
  output logic [LINE_BYTES-1:0][7:0]  dc_line_o,
  output logic                        dc_ready_o,
  // memory
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [ADDR_SIZE-1:0]        mem_addr_o,
  output logic [LINE_BYTES-1:0][7:0]  mem_line_o,
  input  logic [LINE_BYTES-1:0][7:0]  mem_line_i,
  input  logic                        mem_ack_i
);

  localparam logic [ADDR_SIZE-1:0] ALIGN_MASK =
    ~((ADDR_SIZE'(1) << OFFSET_BITS) - ADDR_SIZE'(1));

  arb_state_e                 state_q, state_d;
  logic                       last_dc_q, last_dc_d;
  logic                       owner_dc_q, owner_dc_d;
  logic                       pair_q, pair_d;
  logic [ADDR_SIZE-1:0]       rd_addr_q, rd_addr_d;
  logic                       mem_req_q, mem_req_d;
  logic                       mem_we_q, mem_we_d;
  logic [ADDR_SIZE-1:0]       mem_addr_q, mem_addr_d;
  logic [LINE_BYTES-1:0][7:0] mem_line_q, mem_line_d;
  logic [LINE_BYTES-1:0][7:0] if_line_q, if_line_d;
  logic [LINE_BYTES-1:0][7:0] dc_line_q, dc_line_d;
  logic                       if_ready_q, if_ready_d;
  logic                       dc_ready_q, dc_ready_d;

  logic dc_req_c;
  logic grant_if_c;
  logic mem_done_c;

  // State and output registers
  always_ff @(posedge clk_i or negedge rsn_i) begin
    if (!rsn_i) begin
      state_q    <= ARB_IDLE;
      last_dc_q  <= 1'b0;
      owner_dc_q <= 1'b0;
      pair_q     <= 1'b0;
      rd_addr_q  <= '0;
      mem_req_q  <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= '0;
      mem_line_q <= '0;
      if_line_q  <= '0;
      dc_line_q  <= '0;
      if_ready_q <= 1'b0;
      dc_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      last_dc_q  <= last_dc_d;
      owner_dc_q <= owner_dc_d;
      pair_q     <= pair_d;
      rd_addr_q  <= rd_addr_d;
      mem_req_q  <= mem_req_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_line_q <= mem_line_d;
      if_line_q  <= if_line_d;
      dc_line_q  <= dc_line_d;
      if_ready_q <= if_ready_d;
      dc_ready_q <= dc_ready_d;
    end
  end

  // Grant, memory sequencing and response generation
  always_comb begin
    state_d    = state_q;
    last_dc_d  = last_dc_q;
    owner_dc_d = owner_dc_q;
    pair_d     = pair_q;
    rd_addr_d  = rd_addr_q;
    mem_req_d  = mem_req_q;
    mem_we_d   = mem_we_q;
    mem_addr_d = mem_addr_q;
    mem_line_d = mem_line_q;
    if_line_d  = if_line_q;
    dc_line_d  = dc_line_q;
    if_ready_d = 1'b0;
    dc_ready_d = 1'b0;

    dc_req_c   = dc_rd_i | dc_wr_i;
    // icache wins a tie only when the dcache was served last
    grant_if_c = if_rd_i & (~dc_req_c | last_dc_q);
    // acks arriving with no outstanding request are ignored
    mem_done_c = mem_ack_i & mem_req_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (grant_if_c) begin
          state_d    = ARB_IF_RD;
          owner_dc_d = 1'b0;
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = if_addr_i & ALIGN_MASK;
        end else if (dc_req_c) begin
          owner_dc_d = 1'b1;
          mem_req_d  = 1'b1;
          rd_addr_d  = dc_rd_addr_i & ALIGN_MASK;
          if (dc_wr_i) begin
            state_d    = ARB_DC_WB;
            pair_d     = dc_rd_i;
            mem_we_d   = 1'b1;
            mem_addr_d = dc_wr_addr_i & ALIGN_MASK;
            mem_line_d = dc_wr_line_i;
          end else begin
            state_d    = ARB_DC_RD;
            pair_d     = 1'b0;
            mem_we_d   = 1'b0;
            mem_addr_d = dc_rd_addr_i & ALIGN_MASK;
          end
        end
      end

      ARB_IF_RD: begin
        if (mem_done_c) begin
          state_d    = ARB_RESP;
          mem_req_d  = 1'b0;
          if_line_d  = mem_line_i;
          if_ready_d = 1'b1;
        end
      end

      ARB_DC_WB: begin
        if (mem_done_c) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          if (pair_q) begin
            // refill follows after one idle cycle on the memory port
            state_d    = ARB_DC_RD;
            mem_addr_d = rd_addr_q;
          end else begin
            state_d    = ARB_RESP;
            dc_ready_d = 1'b1;
          end
        end
      end

      ARB_DC_RD: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_done_c) begin
          state_d    = ARB_RESP;
          mem_req_d  = 1'b0;
          dc_line_d  = mem_line_i;
          dc_ready_d = 1'b1;
        end
      end

      ARB_RESP: begin
        last_dc_d = owner_dc_q;
        pair_d    = 1'b0;
        state_d   = ARB_IDLE;
      end

      default: begin
        state_d   = ARB_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  assign if_line_o  = if_line_q;
  assign if_ready_o = if_ready_q;
  assign dc_line_o  = dc_line_q;
  assign dc_ready_o = dc_ready_q;
  assign mem_req_o  = mem_req_q;
  assign mem_we_o   = mem_we_q;
  assign mem_addr_o = mem_addr_q;
  assign mem_line_o = mem_line_q;

endmodule

// File: tb/tb_segre_mem_arbiter.sv
// Scoreboard bench for segre_mem_arbiter with a behavioural memory responder.
module tb_segre_mem_arbiter;
  import segre_pkg::*;

  localparam int unsigned LB = CACHE_LINE_SIZE_BYTES;
  typedef logic [LB-1:0][7:0]     line_t;
  typedef logic [ADDR_SIZE-1:0]   addr_t;

  typedef struct { logic we; addr_t addr; line_t wdata; } exp_acc_t;
  typedef struct { logic we; addr_t addr; line_t wdata; int start; int ack; } obs_acc_t;
  typedef struct { logic dc; line_t line; } exp_rdy_t;
  typedef struct { logic dc; line_t line; int cyc; } obs_rdy_t;

  logic  clk_i = 1'b0;
  logic  rsn_i;
  logic  if_rd_i, dc_rd_i, dc_wr_i, mem_ack_i;
  addr_t if_addr_i, dc_rd_addr_i, dc_wr_addr_i;
  line_t dc_wr_line_i, mem_line_i;
  line_t if_line_o, dc_line_o, mem_line_o;
  logic  if_ready_o, dc_ready_o, mem_req_o, mem_we_o;
  addr_t mem_addr_o;

  segre_mem_arbiter dut (
    .clk_i(clk_i), .rsn_i(rsn_i),
    .if_rd_i(if_rd_i), .if_addr_i(if_addr_i), .if_line_o(if_line_o), .if_ready_o(if_ready_o),
    .dc_rd_i(dc_rd_i), .dc_wr_i(dc_wr_i), .dc_rd_addr_i(dc_rd_addr_i), .dc_wr_addr_i(dc_wr_addr_i),
    .dc_wr_line_i(dc_wr_line_i), .dc_line_o(dc_line_o), .dc_ready_o(dc_ready_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_line_o(mem_line_o), .mem_line_i(mem_line_i), .mem_ack_i(mem_ack_i)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_delay = 0;
  int ack_cnt = 0;
  int req_start = 0;
  int we_viol = 0;
  int addr_viol = 0;
  logic  spur = 1'b0;
  logic  prev_req = 1'b0;
  logic  prev_we = 1'b0;
  addr_t prev_addr = '0;
  line_t exp_dc_line = '0;

  exp_acc_t exp_acc_q[$];
  obs_acc_t obs_acc_q[$];
  exp_rdy_t exp_rdy_q[$];
  obs_rdy_t obs_rdy_q[$];

  // Memory contents: a distinct byte pattern per line address
  function automatic line_t line_pat(input addr_t a);
    line_t l;
    for (int i = 0; i < int'(LB); i++) l[i] = a[11:4] ^ a[19:12] ^ 8'(i * 37);
    return l;
  endfunction

  // One clock: monitor outputs, model requesters dropping after ready, model memory
  task automatic step();
    @(posedge clk_i);
    #1;
    cyc++;
    if (mem_req_o && prev_req) begin
      if (mem_we_o !== prev_we) we_viol++;
      if (mem_addr_o !== prev_addr) addr_viol++;
    end
    if (mem_req_o && !prev_req) req_start = cyc;
    prev_req  = mem_req_o;
    prev_we   = mem_we_o;
    prev_addr = mem_addr_o;
    if (if_ready_o) begin
      obs_rdy_q.push_back('{1'b0, if_line_o, cyc});
      if_rd_i = 1'b0;
    end
    if (dc_ready_o) begin
      obs_rdy_q.push_back('{1'b1, dc_line_o, cyc});
      dc_rd_i = 1'b0;
      dc_wr_i = 1'b0;
    end
    if (mem_ack_i) begin
      mem_ack_i = 1'b0;
    end else if (mem_req_o) begin
      if (ack_cnt == ack_delay) begin
        mem_ack_i  = 1'b1;
        mem_line_i = line_pat(mem_addr_o);
        obs_acc_q.push_back('{mem_we_o, mem_addr_o, mem_line_o, req_start, cyc});
        ack_cnt = 0;
      end else begin
        ack_cnt++;
      end
    end else begin
      ack_cnt = 0;
      if (spur) begin
        mem_ack_i  = 1'b1;
        mem_line_i = '1;
        spur = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rsn_i = 1'b0;
    repeat (2) step();
    rsn_i = 1'b1;
    step();
    obs_acc_q.delete();
    obs_rdy_q.delete();
    exp_dc_line = '0;
  endtask

  task automatic wait_ready(input int n, input string tag);
    for (int i = 0; i < 300 && obs_rdy_q.size() < n; i++) step();
    checks++;
    if (obs_rdy_q.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d ready pulses, required %0d", tag, obs_rdy_q.size(), n);
    end
  endtask

  task automatic test_reset();
    checks++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || if_ready_o !== 1'b0 || dc_ready_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_ctrl: req=%b we=%b ifr=%b dcr=%b, required all 0", mem_req_o, mem_we_o, if_ready_o, dc_ready_o);
    end
    checks++;
    if (mem_addr_o !== '0 || mem_line_o !== '0) begin
      errors++;
      $display("FAIL reset_mem_bus: addr=%h line=%h, required 0", mem_addr_o, mem_line_o);
    end
    checks++;
    if (if_line_o !== '0 || dc_line_o !== '0) begin
      errors++;
      $display("FAIL reset_lines: if=%h dc=%h, required 0", if_line_o, dc_line_o);
    end
    checks++;
    if (dut.state_q !== ARB_IDLE) begin
      errors++;
      $display("FAIL reset_state: got %0d, required ARB_IDLE", dut.state_q);
    end
  endtask

  task automatic test_icache_only();
    int t;
    obs_acc_t oa;
    obs_rdy_t orr;
    ack_delay = 3;
    exp_acc_q.push_back('{1'b0, 32'h100, '0});
    exp_rdy_q.push_back('{1'b0, line_pat(32'h100)});
    t = cyc;
    if_addr_i = 32'h104;
    if_rd_i = 1'b1;
    wait_ready(1, "ic_only");
    step();
    checks++;
    if (dut.state_q !== ARB_IDLE || mem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL ic_idle_after: state=%0d req=%b, required IDLE/0", dut.state_q, mem_req_o);
    end
    repeat (4) step();
    while (exp_acc_q.size() != 0) begin
      exp_acc_t ea = exp_acc_q.pop_front();
      checks++;
      if (obs_acc_q.size() == 0) begin
        errors++;
        $display("FAIL ic_acc missing: required addr %h", ea.addr);
      end else begin
        oa = obs_acc_q.pop_front();
        if (oa.we !== ea.we || oa.addr !== ea.addr) begin
          errors++;
          $display("FAIL ic_acc: we=%b addr=%h, required we=%b addr=%h", oa.we, oa.addr, ea.we, ea.addr);
        end
        checks++;
        if (oa.start != t + 1 || oa.ack != oa.start + 3) begin
          errors++;
          $display("FAIL ic_req_timing: start=%0d ack=%0d, required start=%0d ack=%0d", oa.start, oa.ack, t + 1, t + 4);
        end
      end
    end
    while (exp_rdy_q.size() != 0) begin
      exp_rdy_t er = exp_rdy_q.pop_front();
      checks++;
      if (obs_rdy_q.size() == 0) begin
        errors++;
        $display("FAIL ic_rdy missing");
      end else begin
        orr = obs_rdy_q.pop_front();
        if (orr.dc !== er.dc || orr.line !== er.line || orr.cyc != oa.ack + 1) begin
          errors++;
          $display("FAIL ic_rdy: dc=%b line=%h cyc=%0d, required dc=%b line=%h cyc=%0d", orr.dc, orr.line, orr.cyc, er.dc, er.line, oa.ack + 1);
        end
      end
    end
    checks++;
    if (obs_rdy_q.size() != 0 || obs_acc_q.size() != 0) begin
      errors++;
      $display("FAIL ic_extra: %0d ready, %0d accesses, required 0", obs_rdy_q.size(), obs_acc_q.size());
    end
  endtask

  task automatic test_round_robin();
    logic re = 1'b0;
    do_reset();
    ack_delay = 1;
    exp_acc_q.push_back('{1'b0, 32'h1230, '0});
    exp_acc_q.push_back('{1'b0, 32'h0200, '0});
    exp_acc_q.push_back('{1'b0, 32'h5670, '0});
    exp_rdy_q.push_back('{1'b1, line_pat(32'h1230)});
    exp_rdy_q.push_back('{1'b0, line_pat(32'h0200)});
    exp_rdy_q.push_back('{1'b1, line_pat(32'h5670)});
    exp_dc_line = line_pat(32'h5670);
    if_addr_i = 32'h204;
    dc_rd_addr_i = 32'h1238;
    if_rd_i = 1'b1;
    dc_rd_i = 1'b1;
    for (int i = 0; i < 300 && obs_rdy_q.size() < 3; i++) begin
      step();
      if (!re && obs_rdy_q.size() == 1) begin
        re = 1'b1;
        dc_rd_addr_i = 32'h5678;
        dc_rd_i = 1'b1;
      end
    end
    checks++;
    if (obs_rdy_q.size() < 3) begin
      errors++;
      $display("FAIL rr timeout: %0d ready pulses, required 3", obs_rdy_q.size());
    end
    repeat (3) step();
    while (exp_acc_q.size() != 0) begin
      exp_acc_t ea = exp_acc_q.pop_front();
      checks++;
      if (obs_acc_q.size() == 0) begin
        errors++;
        $display("FAIL rr_acc missing: required addr %h", ea.addr);
      end else begin
        obs_acc_t oa = obs_acc_q.pop_front();
        if (oa.we !== ea.we || oa.addr !== ea.addr) begin
          errors++;
          $display("FAIL rr_acc: we=%b addr=%h, required we=%b addr=%h", oa.we, oa.addr, ea.we, ea.addr);
        end
      end
    end
    while (exp_rdy_q.size() != 0) begin
      exp_rdy_t er = exp_rdy_q.pop_front();
      checks++;
      if (obs_rdy_q.size() == 0) begin
        errors++;
        $display("FAIL rr_rdy missing");
      end else begin
        obs_rdy_t orr = obs_rdy_q.pop_front();
        if (orr.dc !== er.dc || orr.line !== er.line) begin
          errors++;
          $display("FAIL rr_rdy: dc=%b line=%h, required dc=%b line=%h", orr.dc, orr.line, er.dc, er.line);
        end
      end
    end
  endtask

  task automatic test_wb_pair();
    line_t w = line_pat(32'h00ABC000) ^ {LB{8'h5A}};
    obs_acc_t a[3];
    obs_rdy_t r[2];
    do_reset();
    ack_delay = 2;
    we_viol = 0;
    exp_dc_line = line_pat(32'h3040);
    dc_wr_addr_i = 32'h2000;
    dc_wr_line_i = w;
    dc_rd_addr_i = 32'h3040;
    if_addr_i = 32'h400;
    dc_wr_i = 1'b1;
    dc_rd_i = 1'b1;
    if_rd_i = 1'b1;
    wait_ready(2, "pair");
    repeat (4) step();
    checks++;
    if (obs_acc_q.size() != 3 || obs_rdy_q.size() != 2) begin
      errors++;
      $display("FAIL pair_counts: %0d accesses %0d ready, required 3 and 2", obs_acc_q.size(), obs_rdy_q.size());
    end else begin
      for (int i = 0; i < 3; i++) a[i] = obs_acc_q.pop_front();
      for (int i = 0; i < 2; i++) r[i] = obs_rdy_q.pop_front();
      checks++;
      if (a[0].we !== 1'b1 || a[0].addr !== 32'h2000 || a[0].wdata !== w) begin
        errors++;
        $display("FAIL pair_wb: we=%b addr=%h data=%h, required 1/2000/%h", a[0].we, a[0].addr, a[0].wdata, w);
      end
      checks++;
      if (a[1].we !== 1'b0 || a[1].addr !== 32'h3040 || a[1].start != a[0].ack + 2) begin
        errors++;
        $display("FAIL pair_rd: we=%b addr=%h start=%0d, required 0/3040/%0d", a[1].we, a[1].addr, a[1].start, a[0].ack + 2);
      end
      checks++;
      if (r[0].dc !== 1'b1 || r[0].line !== exp_dc_line || r[0].cyc != a[1].ack + 1) begin
        errors++;
        $display("FAIL pair_dc_rdy: dc=%b line=%h cyc=%0d, required 1/%h/%0d", r[0].dc, r[0].line, r[0].cyc, exp_dc_line, a[1].ack + 1);
      end
      checks++;
      if (a[2].addr !== 32'h400 || r[1].dc !== 1'b0 || r[1].line !== line_pat(32'h400)) begin
        errors++;
        $display("FAIL pair_ic_after: addr=%h dc=%b line=%h, required 400/0/%h", a[2].addr, r[1].dc, r[1].line, line_pat(32'h400));
      end
    end
    checks++;
    if (we_viol != 0) begin
      errors++;
      $display("FAIL pair_we_stable: %0d changes of mem_we_o under mem_req_o, required 0", we_viol);
    end
  endtask

  task automatic test_wb_only();
    line_t w2 = ~line_pat(32'h00077000);
    int t;
    obs_acc_t oa;
    obs_rdy_t orr;
    ack_delay = 0;
    obs_acc_q.delete();
    obs_rdy_q.delete();
    t = cyc;
    dc_wr_addr_i = 32'h501C;
    dc_wr_line_i = w2;
    dc_wr_i = 1'b1;
    wait_ready(1, "wb_only");
    repeat (3) step();
    checks++;
    if (obs_acc_q.size() != 1 || obs_rdy_q.size() != 1) begin
      errors++;
      $display("FAIL wb_counts: %0d accesses %0d ready, required 1 and 1", obs_acc_q.size(), obs_rdy_q.size());
    end else begin
      oa = obs_acc_q.pop_front();
      orr = obs_rdy_q.pop_front();
      checks++;
      if (oa.we !== 1'b1 || oa.addr !== 32'h5010 || oa.wdata !== w2) begin
        errors++;
        $display("FAIL wb_acc: we=%b addr=%h data=%h, required 1/5010/%h", oa.we, oa.addr, oa.wdata, w2);
      end
      checks++;
      if (orr.dc !== 1'b1 || orr.line !== exp_dc_line || orr.cyc != t + 2) begin
        errors++;
        $display("FAIL wb_rdy: dc=%b line=%h cyc=%0d, required 1/%h/%0d", orr.dc, orr.line, orr.cyc, exp_dc_line, t + 2);
      end
    end
  endtask

  task automatic test_addr_stable_spurious();
    obs_acc_t oa;
    ack_delay = 4;
    addr_viol = 0;
    obs_acc_q.delete();
    obs_rdy_q.delete();
    if_addr_i = 32'h704;
    if_rd_i = 1'b1;
    for (int i = 0; i < 300 && obs_rdy_q.size() < 1; i++) begin
      step();
      if (mem_req_o) if_addr_i = 32'hFFF0 ^ addr_t'(cyc);
    end
    repeat (2) step();
    checks++;
    if (obs_acc_q.size() != 1 || addr_viol != 0) begin
      errors++;
      $display("FAIL addr_stable: %0d accesses, %0d address changes, required 1 and 0", obs_acc_q.size(), addr_viol);
    end else begin
      oa = obs_acc_q.pop_front();
      checks++;
      if (oa.addr !== 32'h700) begin
        errors++;
        $display("FAIL addr_granted: got %h, required 700", oa.addr);
      end
    end
    obs_rdy_q.delete();
    spur = 1'b1;
    repeat (4) step();
    checks++;
    if (obs_rdy_q.size() != 0 || mem_req_o !== 1'b0 || dut.state_q !== ARB_IDLE) begin
      errors++;
      $display("FAIL spurious_ack: %0d ready, req=%b state=%0d, required 0/0/IDLE", obs_rdy_q.size(), mem_req_o, dut.state_q);
    end
  endtask

  task automatic test_reset_abort();
    obs_rdy_t orr;
    ack_delay = 20;
    obs_acc_q.delete();
    obs_rdy_q.delete();
    if_addr_i = 32'h804;
    if_rd_i = 1'b1;
    repeat (3) step();
    #2;
    rsn_i = 1'b0;
    #1;
    checks++;
    if (mem_req_o !== 1'b0 || mem_we_o !== 1'b0 || if_ready_o !== 1'b0 || dc_ready_o !== 1'b0 ||
        mem_addr_o !== '0 || mem_line_o !== '0 || if_line_o !== '0 || dc_line_o !== '0) begin
      errors++;
      $display("FAIL abort_outputs: req=%b we=%b addr=%h ifl=%h dcl=%h, required all 0", mem_req_o, mem_we_o, mem_addr_o, if_line_o, dc_line_o);
    end
    repeat (2) step();
    rsn_i = 1'b1;
    ack_delay = 1;
    wait_ready(1, "abort_restart");
    repeat (5) step();
    checks++;
    if (obs_rdy_q.size() != 1 || obs_acc_q.size() != 1) begin
      errors++;
      $display("FAIL abort_restart_count: %0d ready %0d accesses, required 1 and 1", obs_rdy_q.size(), obs_acc_q.size());
    end else begin
      orr = obs_rdy_q.pop_front();
      checks++;
      if (orr.dc !== 1'b0 || orr.line !== line_pat(32'h800) || obs_acc_q[0].addr !== 32'h800) begin
        errors++;
        $display("FAIL abort_restart_data: dc=%b line=%h addr=%h, required 0/%h/800", orr.dc, orr.line, obs_acc_q[0].addr, line_pat(32'h800));
      end
    end
  endtask

  initial begin
    rsn_i = 1'b0;
    if_rd_i = 1'b0; dc_rd_i = 1'b0; dc_wr_i = 1'b0; mem_ack_i = 1'b0;
    if_addr_i = '0; dc_rd_addr_i = '0; dc_wr_addr_i = '0;
    dc_wr_line_i = '0; mem_line_i = '0;
    repeat (2) step();
    rsn_i = 1'b1;
    step();
    test_reset();
    test_icache_only();
    test_round_robin();
    test_wb_pair();
    test_wb_only();
    test_addr_stable_spurious();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
